// File: rtl/motores_pkg.sv
// Shared types for the two-axis stepper driver.
// No ports: axis state, move command, coil phase table, command decoder.
package motores_pkg;

   typedef enum logic [1:0] {IDLE, RUN, HOLD} estado_t;
   typedef enum logic [1:0] {NONE, INC, DEC} cmd_t;

   // Full-step pattern {A,B,A',B'} for phase index 0..3.
   localparam logic [3:0] FASES [4] = '{
      4'b0011, 4'b0110, 4'b1100, 4'b1001
   };

   // pos (horario) lowers the angle, neg (anti-horario) raises it.
   function automatic cmd_t decodifica(
      input logic en,
      input logic p,
      input logic n
   );
      cmd_t c;
      unique case (1'b1)
         (en && p && !n): c = DEC;
         (en && n && !p): c = INC;
         default:         c = NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/driver_motores_paso_eje.sv
// One stepper axis: command decode, IDLE/RUN/HOLD FSM, phase, sub-step, angle.
// Ports: clk, rst, en, tick, cmd_pos/cmd_neg -> coil, angle, at_limit, conflict.
module eje_paso
   import motores_pkg::*;
#(
   parameter bit WRAP_MODE     = 1'b0,
   parameter int LO            = 0,
   parameter int HI            = 180,
   parameter int STEPS_PER_DEG = 8,
   parameter int HOLD_TICKS    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        tick,
   input  logic        cmd_pos,
   input  logic        cmd_neg,
   output logic [3:0]  coil,
   output logic [15:0] angle,
   output logic        at_limit,
   output logic        conflict
);

   localparam logic [15:0] LO_A     = 16'(LO);
   localparam logic [15:0] HI_A     = 16'(HI);
   localparam logic [15:0] SUB_TOP  = 16'(STEPS_PER_DEG - 1);
   localparam logic [15:0] HOLD_TOP = 16'(HOLD_TICKS - 1);

   estado_t     estado_q, estado_d;
   cmd_t        cmd, dir_q, dir_d;
   logic [1:0]  fase_q, fase_d;
   logic [3:0]  coil_q, coil_d;
   logic [15:0] sub_q, sub_d;
   logic [15:0] hold_q, hold_d;
   logic [15:0] angle_q, angle_d;
   logic        bloqueo, lim_q, conf_q;

   always_comb begin
      cmd      = decodifica(en, cmd_pos, cmd_neg);
      bloqueo  = !WRAP_MODE &&
                 ((cmd == INC && angle_q == HI_A) ||
                  (cmd == DEC && angle_q == LO_A));
      estado_d = estado_q;
      dir_d    = dir_q;
      fase_d   = fase_q;
      coil_d   = coil_q;
      sub_d    = sub_q;
      hold_d   = hold_q;
      angle_d  = angle_q;

      // A new direction restarts the partial degree.
      if (cmd != NONE && cmd != dir_q) begin
         sub_d = '0;
         dir_d = cmd;
      end

      unique case (estado_q)
         IDLE: begin
            coil_d = '0;
            if (cmd != NONE) estado_d = RUN;
         end
         RUN: begin
            if (cmd == NONE) begin
               estado_d = HOLD;
               hold_d   = '0;
            end else if (tick && !bloqueo) begin
               fase_d = (cmd == INC) ? fase_q + 2'd1
                                     : fase_q - 2'd1;
               coil_d = FASES[fase_d];
               if (sub_d == SUB_TOP) begin
                  sub_d = '0;
                  if (cmd == INC)
                     angle_d = (WRAP_MODE && angle_q == HI_A)
                               ? LO_A : angle_q + 16'd1;
                  else
                     angle_d = (WRAP_MODE && angle_q == LO_A)
                               ? HI_A : angle_q - 16'd1;
               end else begin
                  sub_d = sub_d + 16'd1;
               end
            end
         end
         HOLD: begin
            if (cmd != NONE) begin
               estado_d = RUN;
               hold_d   = '0;
            end else if (tick) begin
               if (hold_q == HOLD_TOP) begin
                  estado_d = IDLE;
                  coil_d   = '0;
                  hold_d   = '0;
               end else begin
                  hold_d = hold_q + 16'd1;
               end
            end
         end
         default: estado_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q <= IDLE;
         dir_q    <= NONE;
         fase_q   <= '0;
         coil_q   <= '0;
         sub_q    <= '0;
         hold_q   <= '0;
         angle_q  <= LO_A;
         lim_q    <= 1'b0;
         conf_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         dir_q    <= dir_d;
         fase_q   <= fase_d;
         coil_q   <= coil_d;
         sub_q    <= sub_d;
         hold_q   <= hold_d;
         angle_q  <= angle_d;
         lim_q    <= bloqueo;
         conf_q   <= en & cmd_pos & cmd_neg;
      end
   end

   assign coil     = coil_q;
   assign angle    = angle_q;
   assign at_limit = lim_q;
   assign conflict = conf_q;

endmodule

// File: rtl/driver_motores_paso.sv
// Two-axis stepper driver: shared step prescaler plus theta/phi axes.
// Ports: clk, rst, en, per-axis pos/neg -> coils, angles, limit, conflict.
module driver_motores_paso
   import motores_pkg::*;
#(
   parameter int CLK_DIV       = 50000,
   parameter int STEPS_PER_DEG = 8,
   parameter int HOLD_TICKS    = 4,
   parameter int THETA_MIN     = 0,
   parameter int THETA_MAX     = 180,
   parameter int PHI_WRAP      = 360
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  s_in_theta_pos,
   input  logic [1:0]  s_in_theta_neg,
   input  logic [1:0]  s_in_phi_pos,
   input  logic [1:0]  s_in_phi_neg,
   output logic [3:0]  coil_theta,
   output logic [3:0]  coil_phi,
   output logic [15:0] theta_actual,
   output logic [15:0] phi_actual,
   output logic        theta_at_limit,
   output logic        cmd_conflict
);

   localparam int PW = $clog2(CLK_DIV);

   logic [PW-1:0] presc_q;
   logic          tick;
   logic          conf_t, conf_p, lim_p;
   logic          unused_bits;

   // Upper command bits carry no meaning.
   assign unused_bits = ^{s_in_theta_pos[1], s_in_theta_neg[1],
                          s_in_phi_pos[1], s_in_phi_neg[1], lim_p};

   assign tick = (presc_q == PW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)       presc_q <= '0;
      else if (tick) presc_q <= '0;
      else           presc_q <= presc_q + 1'b1;
   end

   eje_paso #(
      .WRAP_MODE     (1'b0),
      .LO            (THETA_MIN),
      .HI            (THETA_MAX),
      .STEPS_PER_DEG (STEPS_PER_DEG),
      .HOLD_TICKS    (HOLD_TICKS)
   ) u_theta (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .tick     (tick),
      .cmd_pos  (s_in_theta_pos[0]),
      .cmd_neg  (s_in_theta_neg[0]),
      .coil     (coil_theta),
      .angle    (theta_actual),
      .at_limit (theta_at_limit),
      .conflict (conf_t)
   );

   eje_paso #(
      .WRAP_MODE     (1'b1),
      .LO            (0),
      .HI            (PHI_WRAP - 1),
      .STEPS_PER_DEG (STEPS_PER_DEG),
      .HOLD_TICKS    (HOLD_TICKS)
   ) u_phi (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .tick     (tick),
      .cmd_pos  (s_in_phi_pos[0]),
      .cmd_neg  (s_in_phi_neg[0]),
      .coil     (coil_phi),
      .angle    (phi_actual),
      .at_limit (lim_p),
      .conflict (conf_p)
   );

   assign cmd_conflict = conf_t | conf_p;

endmodule
